operand_entry_fsm: RTL
======================

# operand_entry_fsm

Collects the keypad key stream for the calculator. It builds two packed-BCD operands and their digit counts, and latches the operator. On the equals key it presents a complete, stable expression to the downstream `calculate` stage. It sits between the key decoder and `calculate`, and drives that stage's `reg_num1`, `reg_num2`, `sym`, `cnt1` and `cnt2` inputs.

## Interface
- `MAX_DIGITS`, default 4: maximum digits per operand. The packed operand width is `4*MAX_DIGITS`.
- `clk`, input, 1: system clock. There is one clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `key_valid`, input, 1: single-cycle strobe marking `key_code` as a new key.
- `key_code`, input, 8: ASCII key code, sampled only when `key_valid` is high.
  - `0x30`–`0x39`: digits 0–9.
  - `0x61` add, `0x62` sub, `0x63` mul, `0x64` div.
  - `0x65`: equals.
  - `0x66`: clear.
  - All other codes are ignored.
- `reg_num1`, output, `4*MAX_DIGITS`: operand 1, packed BCD. Bits [3:0] hold the ones digit.
- `reg_num2`, output, `4*MAX_DIGITS`: operand 2, same packing as `reg_num1`.
- `cnt1`, output, 3: number of digits entered for operand 1 (0..`MAX_DIGITS`).
- `cnt2`, output, 3: number of digits entered for operand 2.
- `sym`, output, 8: latched operator code (`0x61`–`0x64`). Holds `0x00` when no operator is latched.
- `calc_valid`, output, 1: one-cycle pulse meaning the expression is complete and stable.
- `div_zero`, output, 1: one-cycle pulse issued in place of `calc_valid` when the expression divides by zero.
- `ovf`, output, 1: sticky flag set when a digit is dropped because the operand is full.
- `stage`, output, 2: current state, for the display. 0 = OP1, 1 = OP2, 2 = DONE.

## Operation
- **States:** OP1 (entering operand 1), OP2 (entering operand 2), DONE (expression complete).
- **Digit entry:**
  - Each accepted digit shifts into the active operand: `num <= {num[4*MAX_DIGITS-5:0], digit}` and `cnt <= cnt+1`.
  - The digit value is `key_code - 0x30`.
  - The most recently entered digit is therefore always the ones digit.
- **OP1 transitions:**
  - Digit with `cnt1<MAX_DIGITS`: accepted.
  - Digit with `cnt1==MAX_DIGITS`: dropped, and `ovf` is set.
  - Operator key with `cnt1>0`: latch `sym`, go to OP2.
  - Operator key with `cnt1==0`: ignored.
  - Equals: ignored.
- **OP2 transitions:**
  - Digits: handled as in OP1, but into `reg_num2`/`cnt2`.
  - Operator key with `cnt2==0`: replaces `sym`.
  - Operator key with `cnt2>0`: ignored; operator chaining is not supported.
  - Equals with `cnt2==0`: ignored.
  - Equals with `cnt2>0`: go to DONE and pulse `calc_valid`.
  - Equals with `cnt2>0`, `sym==0x64` and `reg_num2` all zero digits: go to DONE and pulse `div_zero` instead of `calc_valid`.
- **DONE transitions:**
  - Operands, counts and `sym` are held unchanged.
  - Digit key: clear everything (`ovf` included), load the digit as operand 1's first digit (`cnt1=1`), go to OP1.
  - Operator key and equals: ignored.
- **Clear key (`0x66`), any state:** same effect as reset.
- **Leading zeros:** counted as digits. Entering `0`,`5` gives `cnt1=2`, `reg_num1[7:0]=0x05`.
- **Packing:** digits above position `cnt` are always 0.

## Timing
- **Reset:** the cycle after `rst` is sampled high, outputs are:
  - `reg_num1=0`, `reg_num2=0`, `cnt1=0`, `cnt2=0`, `sym=0x00`
  - `calc_valid=0`, `div_zero=0`, `ovf=0`, `stage=0`
- `rst` overrides `key_valid` in the same cycle. Reset mid-entry discards all partial input.
- **Latency:** all outputs are registered. A key sampled at edge N is reflected in outputs after edge N.
  - `calc_valid`/`div_zero` go high for exactly the one cycle following the equals key.
- **Output stability:** operands, counts and `sym` are stable from the `calc_valid` cycle until the next accepted digit or clear. Downstream may sample at any time in DONE.
- **Key throughput:** one key per cycle is accepted.
  - `key_valid` held high for K cycles is treated as K key presses.
  - The upstream decoder guarantees single-cycle strobes.
- **`ovf`:** stays high until clear, reset, or a new expression started from DONE.

## Test plan
- Reset, then keys `1`,`2`,`a`,`3`,`e`: `reg_num1=0x0012`, `cnt1=2`, `reg_num2=0x0003`, `cnt2=1`, `sym=0x61`, and `calc_valid` high for exactly 1 cycle, 1 cycle after `e`.
- Keys `9`,`8`,`7`,`6`,`5`: `reg_num1=0x9876`, `cnt1=4`, `ovf=1`. Then `c`,`2`,`e`: `sym=0x63`, `calc_valid` pulses, `ovf` still 1.
- Keys `a` then `e` immediately after reset: both ignored, `stage=0`, `sym=0x00`. Then `4`,`b`,`c`,`7`,`e`: `sym=0x63` (replaced), `reg_num2=0x0007`.
- Keys `8`,`d`,`0`,`e`: `div_zero` pulses for 1 cycle, `calc_valid` stays 0, `stage=2`.
- From DONE, key `5`: `reg_num1=0x0005`, `cnt1=1`, `cnt2=0`, `reg_num2=0`, `sym=0`, `stage=0`.
- Mid-entry `1`,`a`,`2`, then `rst` asserted in the same cycle as a `3` strobe: all outputs at reset values and the `3` is discarded. Repeat with key `0x66` instead of `rst`: same result.

Source files
------------

// File: rtl/operand_entry_fsm.sv
// Keypad operand collector: builds two packed-BCD operands plus an operator and
// presents the finished expression to the calculate stage on the equals key.
module operand_entry_fsm #(
   parameter int MAX_DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      key_valid,
   input  logic [7:0]                key_code,
   output logic [4*MAX_DIGITS-1:0]   reg_num1,
   output logic [4*MAX_DIGITS-1:0]   reg_num2,
   output logic [2:0]                cnt1,
   output logic [2:0]                cnt2,
   output logic [7:0]                sym,
   output logic                      calc_valid,
   output logic                      div_zero,
   output logic                      ovf,
   output logic [1:0]                stage
);

   localparam int         W       = 4 * MAX_DIGITS;
   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);
   localparam logic [7:0] KEY_DIV = 8'h64;

   typedef enum logic [1:0] {
      ST_OP1  = 2'd0,
      ST_OP2  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [W-1:0] num1_q, num1_d;
   logic [W-1:0] num2_q, num2_d;
   logic [2:0]   cnt1_q, cnt1_d;
   logic [2:0]   cnt2_q, cnt2_d;
   logic [7:0]   sym_q, sym_d;
   logic         calc_valid_q, calc_valid_d;
   logic         div_zero_q, div_zero_d;
   logic         ovf_q, ovf_d;

   logic       is_digit, is_op, is_eq, is_clr;
   logic [3:0] digit;
   logic       div_by_zero;

   // ASCII digits 0x30..0x39 carry their value in the low nibble.
   assign digit       = key_code[3:0];
   assign is_digit    = key_valid && (key_code >= 8'h30) && (key_code <= 8'h39);
   assign is_op       = key_valid && (key_code >= 8'h61) && (key_code <= 8'h64);
   assign is_eq       = key_valid && (key_code == 8'h65);
   assign is_clr      = key_valid && (key_code == 8'h66);
   assign div_by_zero = (sym_q == KEY_DIV) && (num2_q == '0);

   // State register together with the datapath registers it qualifies.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge values of the others, regardless of statement order.
      if (rst) begin
         state_q      <= ST_OP1;
         num1_q       <= '0;
         num2_q       <= '0;
         cnt1_q       <= '0;
         cnt2_q       <= '0;
         sym_q        <= '0;
         calc_valid_q <= 1'b0;
         div_zero_q   <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         num1_q       <= num1_d;
         num2_q       <= num2_d;
         cnt1_q       <= cnt1_d;
         cnt2_q       <= cnt2_d;
         sym_q        <= sym_d;
         calc_valid_q <= calc_valid_d;
         div_zero_q   <= div_zero_d;
         ovf_q        <= ovf_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      if (is_clr) begin
         state_d = ST_OP1;
      end else begin
         unique case (state_q)
            ST_OP1:  if (is_op && (cnt1_q != '0)) state_d = ST_OP2;
            ST_OP2:  if (is_eq && (cnt2_q != '0)) state_d = ST_DONE;
            ST_DONE: if (is_digit)                state_d = ST_OP1;
            default: state_d = ST_OP1;
         endcase
      end
   end

   // Registered-output next values: operands, counts, operator and pulses.
   always_comb begin
      num1_d       = num1_q;
      num2_d       = num2_q;
      cnt1_d       = cnt1_q;
      cnt2_d       = cnt2_q;
      sym_d        = sym_q;
      ovf_d        = ovf_q;
      calc_valid_d = 1'b0;
      div_zero_d   = 1'b0;

      if (is_clr) begin
         num1_d = '0;
         num2_d = '0;
         cnt1_d = '0;
         cnt2_d = '0;
         sym_d  = '0;
         ovf_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_OP1: begin
               if (is_digit) begin
                  if (cnt1_q < MAX_CNT) begin
                     num1_d = {num1_q[W-5:0], digit};
                     cnt1_d = cnt1_q + 3'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               if (is_op && (cnt1_q != '0)) sym_d = key_code;
            end
            ST_OP2: begin
               if (is_digit) begin
                  if (cnt2_q < MAX_CNT) begin
                     num2_d = {num2_q[W-5:0], digit};
                     cnt2_d = cnt2_q + 3'd1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               // Operator may be corrected only before operand 2 starts.
               if (is_op && (cnt2_q == '0)) sym_d = key_code;
               if (is_eq && (cnt2_q != '0)) begin
                  if (div_by_zero) div_zero_d   = 1'b1;
                  else             calc_valid_d = 1'b1;
               end
            end
            ST_DONE: begin
               if (is_digit) begin
                  num1_d = W'(digit);
                  cnt1_d = 3'd1;
                  num2_d = '0;
                  cnt2_d = '0;
                  sym_d  = '0;
                  ovf_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign reg_num1   = num1_q;
   assign reg_num2   = num2_q;
   assign cnt1       = cnt1_q;
   assign cnt2       = cnt2_q;
   assign sym        = sym_q;
   assign calc_valid = calc_valid_q;
   assign div_zero   = div_zero_q;
   assign ovf        = ovf_q;
   assign stage      = state_q;

endmodule
